// File: rtl/trade_pkg.sv
// Shared constants and entry layout for the trade history buffer.
// Entry word layout (MSB..LSB): {buy, sell, spread}, each DW bits wide.
package trade_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned EW    = 3 * DW;

  // Field slot numbers within an entry word; bit offset = slot * DW
  localparam int unsigned SPREAD_FIELD = 0;
  localparam int unsigned SELL_FIELD   = 1;
  localparam int unsigned BUY_FIELD    = 2;

  typedef struct packed {
    logic [DW-1:0] buy;
    logic [DW-1:0] sell;
    logic [DW-1:0] spread;
  } trade_entry_t;

endpackage

// File: rtl/trade_hist_ram.sv
// Simple dual-port trade storage: synchronous write, registered read.
// A read of the slot being written in the same cycle returns the old word.
// The read register can be cleared so invalid reads present zero.
module trade_hist_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned EW    = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  input  logic          rclr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; non-blocking ordering gives read-old on collision
  always_ff @(posedge clk) begin
    if (reset || rclr) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/trade_history_buffer.sv
// Ring buffer of the most recent matched trades with a frame-stable,
// newest-first read port for the display.
// Optional running spread statistics: define TRADE_HISTORY_STATS_EN.
module trade_history_buffer
  import trade_pkg::*;
#(
  parameter int unsigned DEPTH = trade_pkg::DEPTH,
  parameter int unsigned AW    = trade_pkg::AW,
  parameter int unsigned DW    = trade_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] buy_price,
  input  logic [DW-1:0] sell_price,
  input  logic [DW-1:0] spread,
  input  logic          match_siganl,
  input  logic          halt_signal,
  input  logic          frame_start,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_buy,
  output logic [DW-1:0] rd_sell,
  output logic [DW-1:0] rd_spread,
  output logic          rd_valid,
  output logic [AW:0]   hist_count,
  output logic [DW-1:0] spread_max,
  output logic [DW-1:0] spread_min
);

  localparam int unsigned EWL     = 3 * DW;
  localparam int unsigned BUY_OFS = BUY_FIELD * DW;
  localparam int unsigned SEL_OFS = SELL_FIELD * DW;
  localparam int unsigned SPR_OFS = SPREAD_FIELD * DW;

  logic          match_d;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   live_count;
  logic [AW-1:0] snap_ptr;
  logic [AW:0]   snap_count;

  logic          capture;
  logic [AW-1:0] raddr;
  logic          rd_hit;
  logic [EWL-1:0] wdata;
  logic [EWL-1:0] rdata;

  // Rising-edge capture gated by halt; physical read address from snapshot
  always_comb begin
    capture = match_siganl & ~match_d & ~halt_signal;
    raddr   = snap_ptr - AW'(1) - rd_idx;
    rd_hit  = ({1'b0, rd_idx} < snap_count);
    wdata   = {buy_price, sell_price, spread};
  end

  // Match edge detector, write pointer and live occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      match_d    <= 1'b0;
      wr_ptr     <= '0;
      live_count <= '0;
    end else begin
      match_d <= match_siganl;
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (live_count != (AW+1)'(DEPTH)) begin
          live_count <= live_count + (AW+1)'(1);
        end
      end
    end
  end

  // Frame snapshot; takes pre-capture values when capture coincides
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_ptr   <= '0;
      snap_count <= '0;
    end else if (frame_start) begin
      snap_ptr   <= wr_ptr;
      snap_count <= live_count;
    end
  end

  // Read valid tracks the registered RAM read
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
    end
  end

  assign hist_count = snap_count;

  trade_hist_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .EW    (EWL)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (raddr),
    .rclr  (~rd_hit),
    .rdata (rdata)
  );

  assign rd_buy    = rdata[BUY_OFS +: DW];
  assign rd_sell   = rdata[SEL_OFS +: DW];
  assign rd_spread = rdata[SPR_OFS +: DW];

`ifdef TRADE_HISTORY_STATS_EN
  logic [DW-1:0] max_q;
  logic [DW-1:0] min_q;

  // Running spread extremes, updated alongside the memory write
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
      min_q <= '1;
    end else if (capture) begin
      if (spread > max_q) max_q <= spread;
      if (spread < min_q) min_q <= spread;
    end
  end

  assign spread_max = max_q;
  assign spread_min = min_q;
`else
  assign spread_max = '0;
  assign spread_min = '1;
`endif

endmodule

// File: tb/tb_trade_history_buffer.sv
// Scoreboard bench for trade_history_buffer: read requests push hand-computed
// expectations; a monitor pops and compares one cycle later.
module tb_trade_history_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buy_price, sell_price, spread;
  logic       match_siganl, halt_signal, frame_start;
  logic [2:0] rd_idx;
  logic [7:0] rd_buy, rd_sell, rd_spread;
  logic       rd_valid;
  logic [3:0] hist_count;
  logic [7:0] spread_max, spread_min;

  logic       rd_req;
  int         n_tests = 0;
  int         n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] buy, sell, spr;
    logic       v;
    logic [3:0] hc;
    logic [7:0] mx, mn;
  } exp_t;

  exp_t sb[$];

  always #20 clk = ~clk;

  trade_history_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .buy_price    (buy_price),
    .sell_price   (sell_price),
    .spread       (spread),
    .match_siganl (match_siganl),
    .halt_signal  (halt_signal),
    .frame_start  (frame_start),
    .rd_idx       (rd_idx),
    .rd_buy       (rd_buy),
    .rd_sell      (rd_sell),
    .rd_spread    (rd_spread),
    .rd_valid     (rd_valid),
    .hist_count   (hist_count),
    .spread_max   (spread_max),
    .spread_min   (spread_min)
  );

  task automatic chk(input string name, input string fld, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, fld, act, exp);
    end
  endtask

  // Monitor: a request issued before this edge is answered just after it
  initial begin
    forever begin
      logic pending;
      exp_t e;
      @(posedge clk);
      pending = rd_req;
      #1;
      if (pending) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: read observed with empty queue");
        end else begin
          e = sb.pop_front();
          chk(e.name, "rd_buy",     int'(rd_buy),     int'(e.buy));
          chk(e.name, "rd_sell",    int'(rd_sell),    int'(e.sell));
          chk(e.name, "rd_spread",  int'(rd_spread),  int'(e.spr));
          chk(e.name, "rd_valid",   int'(rd_valid),   int'(e.v));
          chk(e.name, "hist_count", int'(hist_count), int'(e.hc));
          chk(e.name, "spread_max", int'(spread_max), int'(e.mx));
          chk(e.name, "spread_min", int'(spread_min), int'(e.mn));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; match_siganl = 1'b0; halt_signal = 1'b0; frame_start = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic capture(input logic [7:0] b, input logic [7:0] s, input logic [7:0] sp);
    buy_price = b; sell_price = s; spread = sp; match_siganl = 1'b1;
    tick();
    match_siganl = 1'b0;
    tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Issue a read and queue its expectation; stats expectations apply only
  // when the statistics feature is built
  task automatic rd(input string name, input logic [2:0] idx,
                    input logic [7:0] b, input logic [7:0] s, input logic [7:0] sp,
                    input logic v, input logic [3:0] hc,
                    input logic [7:0] mx, input logic [7:0] mn);
    exp_t e;
    e.name = name; e.buy = b; e.sell = s; e.spr = sp; e.v = v; e.hc = hc;
`ifdef TRADE_HISTORY_STATS_EN
    e.mx = mx; e.mn = mn;
`else
    e.mx = 8'd0; e.mn = 8'hFF;
`endif
    sb.push_back(e);
    rd_idx = idx; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    rd_req = 1'b0; rd_idx = '0;
    buy_price = '0; sell_price = '0; spread = '0;
    do_reset();

    // Empty after reset
    frame();
    rd("reset_empty", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'hFF);

    // Single capture
    capture(8'd50, 8'd48, 8'd2);
    frame();
    rd("single_idx0", 3'd0, 50, 48, 2, 1, 1, 2, 2);
    rd("single_idx1", 3'd1, 0, 0, 0, 0, 1, 2, 2);

    // Level held 20 cycles gives one capture
    buy_price = 8'd60; sell_price = 8'd59; spread = 8'd1; match_siganl = 1'b1;
    repeat (20) tick();
    match_siganl = 1'b0; tick();
    // Rising edge while halted, still high at release: no capture
    halt_signal = 1'b1; tick();
    buy_price = 8'd70; sell_price = 8'd69; spread = 8'd0; match_siganl = 1'b1;
    repeat (3) tick();
    halt_signal = 1'b0; repeat (3) tick();
    match_siganl = 1'b0; tick();
    frame();
    rd("held_idx0", 3'd0, 60, 59, 1, 1, 2, 2, 1);
    rd("held_idx1", 3'd1, 50, 48, 2, 1, 2, 2, 1);
    rd("held_idx2", 3'd2, 0, 0, 0, 0, 2, 2, 1);

    // Wrap: ten captures into eight slots
    do_reset();
    for (int i = 1; i <= 10; i++) capture(8'(i), 8'(i + 100), 8'(i));
    frame();
    rd("wrap_idx0", 3'd0, 10, 110, 10, 1, 8, 10, 1);
    rd("wrap_idx3", 3'd3, 7, 107, 7, 1, 8, 10, 1);
    rd("wrap_idx7", 3'd7, 3, 103, 3, 1, 8, 10, 1);

    // Capture coincident with frame_start is deferred to the next frame
    buy_price = 8'd200; sell_price = 8'd190; spread = 8'd10;
    match_siganl = 1'b1; frame_start = 1'b1;
    tick();
    match_siganl = 1'b0; frame_start = 1'b0;
    tick();
    rd("coinc_before", 3'd0, 10, 110, 10, 1, 8, 10, 1);
    frame();
    rd("coinc_after0", 3'd0, 200, 190, 10, 1, 8, 10, 1);
    rd("coinc_after7", 3'd7, 4, 104, 4, 1, 8, 10, 1);

    // Stats sequence, then mid-sequence reset
    do_reset();
    capture(8'd11, 8'd6, 8'd5);
    capture(8'd12, 8'd10, 8'd2);
    capture(8'd13, 8'd4, 8'd9);
    frame();
    rd("stats_idx0", 3'd0, 13, 4, 9, 1, 3, 9, 2);
    rd("stats_idx2", 3'd2, 11, 6, 5, 1, 3, 9, 2);
    do_reset();
    frame();
    rd("midreset", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'hFF);
    capture(8'd77, 8'd76, 8'd1);
    frame();
    rd("post_reset", 3'd0, 77, 76, 1, 1, 1, 1, 1);

    repeat (3) tick();
    chk("drain", "queue_left", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "timeout");
  end

endmodule
